// File: rtl/wb_stage_mux_pkg.sv
// Shared encodings for the MIPS write-back stage: write-data source codes
// and load-size codes.
package wb_pkg;

  // Write-data source select codes (WbSel values)
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_MEM = 1;
  localparam int WB_SRC_PC4 = 2;
  localparam int WB_SRC_LUI = 3;

  // Load access size; 2'b11 is reserved and always flagged as an error
  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_RSVD = 2'b11
  } ldSize_e;

endpackage

// File: rtl/wb_stage_mux_load_extend.sv
// Sub-word load extraction and zero/sign extension of an aligned memory word.
// byteAddr is the low two bits of the effective address; all lanes live in
// the low 32 bits of the word (DATA_W is expected to be 32 or wider).
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] memData,
  input  logic [1:0]        byteAddr,
  input  logic [1:0]        loadSize,
  input  logic              loadSigned,
  output logic [DATA_W-1:0] extData,
  output logic              misaligned
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Pick the addressed lane and extend it; flag accesses that cross their natural alignment
  always_comb begin
    byteLane   = memData[7:0];
    halfLane   = byteAddr[1] ? memData[31:16] : memData[15:0];
    extData    = memData;
    misaligned = 1'b0;

    case (byteAddr)
      2'd0:    byteLane = memData[7:0];
      2'd1:    byteLane = memData[15:8];
      2'd2:    byteLane = memData[23:16];
      default: byteLane = memData[31:24];
    endcase

    case (loadSize)
      LD_WORD: begin
        extData    = memData;
        misaligned = (byteAddr != 2'd0);
      end
      LD_HALF: begin
        extData    = {{(DATA_W-16){loadSigned & halfLane[15]}}, halfLane};
        misaligned = byteAddr[0];
      end
      LD_BYTE: begin
        extData    = {{(DATA_W-8){loadSigned & byteLane[7]}}, byteLane};
        misaligned = 1'b0;
      end
      default: begin
        // Reserved size: data passes as a word but is never written back
        extData    = memData;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage_mux.sv
// MIPS write-back stage: NSRC-way register-file write-data select, sub-word
// load extension, MEM/WB pipeline register with stall/flush, and a saturating
// counter of retired register writes.
//
// Handshake: in_valid qualifies every MEM-stage input on the edge it is
// sampled; there is no ready. The only back-pressure is stall, which holds the
// MEM/WB register. wb_valid marks the registered slot as holding a real
// instruction; RegWrite is already qualified by wb_valid and by error-freedom.
module wb_stage_mux
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int REG_W  = 5,
  parameter  int NSRC   = 4,
  parameter  int CNT_W  = 16,
  localparam int SEL_W  = $clog2(NSRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [SEL_W-1:0]  WbSel,
  input  logic              RegWrite_in,
  input  logic [REG_W-1:0]  WriteReg_in,
  input  logic [DATA_W-1:0] ResultadoF_ALU,
  input  logic [DATA_W-1:0] Exit_DataMem,
  input  logic [DATA_W-1:0] PC_plus4,
  input  logic [DATA_W-1:0] Imm_upper,
  input  logic [1:0]        LoadSize,
  input  logic              LoadSigned,
  output logic [DATA_W-1:0] Write_Data,
  output logic [REG_W-1:0]  WriteReg,
  output logic              RegWrite,
  output logic              wb_valid,
  output logic              wb_err,
  output logic [CNT_W-1:0]  wb_count
);

  logic [DATA_W-1:0] memExt;
  logic              memMisaligned;
  logic [DATA_W-1:0] selData;
  logic              illegalSel;
  logic              selErr;
  logic              writeEn;

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .memData    (Exit_DataMem),
    .byteAddr   (ResultadoF_ALU[1:0]),
    .loadSize   (LoadSize),
    .loadSigned (LoadSigned),
    .extData    (memExt),
    .misaligned (memMisaligned)
  );

  // Write-data source select, error detection and write-enable qualification
  always_comb begin
    illegalSel = (int'(WbSel) >= NSRC);
    selData    = '0;
    if (!illegalSel) begin
      case (int'(WbSel))
        WB_SRC_ALU: selData = ResultadoF_ALU;
        WB_SRC_MEM: selData = memExt;
        WB_SRC_PC4: selData = PC_plus4;
        WB_SRC_LUI: selData = Imm_upper;
        default:    selData = '0;
      endcase
    end
    selErr  = illegalSel | ((int'(WbSel) == WB_SRC_MEM) & memMisaligned);
    // $zero is hard-wired, so a write to it is dropped rather than issued
    writeEn = in_valid & RegWrite_in & (WriteReg_in != '0) & ~selErr;
  end

  // MEM/WB register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Write_Data <= '0;
      WriteReg   <= '0;
      RegWrite   <= 1'b0;
      wb_valid   <= 1'b0;
      wb_err     <= 1'b0;
    end else if (flush) begin
      Write_Data <= '0;
      WriteReg   <= '0;
      RegWrite   <= 1'b0;
      wb_valid   <= 1'b0;
      wb_err     <= 1'b0;
    end else if (!stall) begin
      Write_Data <= selData;
      WriteReg   <= WriteReg_in;
      RegWrite   <= writeEn;
      wb_valid   <= in_valid;
      wb_err     <= in_valid & selErr;
    end
  end

  // Retired-write counter: a write held in WB counts once, on the edge it
  // leaves without a stall; the count saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_count <= '0;
    end else if (RegWrite && !stall && (wb_count != {CNT_W{1'b1}})) begin
      wb_count <= wb_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_wb_stage_mux.sv
// Bench for wb_stage_mux. Two instances share stimulus: dutA is the standard
// four-source stage with a narrow counter so saturation is reachable; dutB
// has NSRC=3, which makes WbSel=3 an illegal select.
module tb_wb_stage_mux;

  typedef struct {
    logic        rstn;
    logic        stall;
    logic        flush;
    logic        valid;
    logic        rwi;
    logic [1:0]  sel;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [1:0]  sz;
    logic        sg;
  } stim_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        rw;
    logic        valid;
    logic        err;
    int          cnt;
    bit          dataCare;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  WbSel = '0;
  logic        RegWrite_in = 1'b0;
  logic [4:0]  WriteReg_in = '0;
  logic [31:0] ResultadoF_ALU = '0;
  logic [31:0] Exit_DataMem = '0;
  logic [31:0] PC_plus4 = '0;
  logic [31:0] Imm_upper = '0;
  logic [1:0]  LoadSize = '0;
  logic        LoadSigned = 1'b0;

  logic [31:0] aData, bData;
  logic [4:0]  aReg, bReg;
  logic        aRw, bRw, aValid, bValid, aErr, bErr;
  logic [3:0]  aCount;
  logic [2:0]  bCount;

  wb_stage_mux #(.DATA_W(32), .REG_W(5), .NSRC(4), .CNT_W(4)) dutA (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .WbSel(WbSel), .RegWrite_in(RegWrite_in), .WriteReg_in(WriteReg_in),
    .ResultadoF_ALU(ResultadoF_ALU), .Exit_DataMem(Exit_DataMem), .PC_plus4(PC_plus4),
    .Imm_upper(Imm_upper), .LoadSize(LoadSize), .LoadSigned(LoadSigned),
    .Write_Data(aData), .WriteReg(aReg), .RegWrite(aRw), .wb_valid(aValid),
    .wb_err(aErr), .wb_count(aCount)
  );

  wb_stage_mux #(.DATA_W(32), .REG_W(5), .NSRC(3), .CNT_W(3)) dutB (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .WbSel(WbSel), .RegWrite_in(RegWrite_in), .WriteReg_in(WriteReg_in),
    .ResultadoF_ALU(ResultadoF_ALU), .Exit_DataMem(Exit_DataMem), .PC_plus4(PC_plus4),
    .Imm_upper(Imm_upper), .LoadSize(LoadSize), .LoadSigned(LoadSigned),
    .Write_Data(bData), .WriteReg(bReg), .RegWrite(bRw), .wb_valid(bValid),
    .wb_err(bErr), .wb_count(bCount)
  );

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  int          nsrcOf[2] = '{4, 3};
  int          cntMax[2] = '{15, 7};
  logic [31:0] mData[2];
  logic [4:0]  mReg[2];
  logic        mRw[2], mValid[2], mErr[2];
  int          mCnt[2];
  bit          mCare[2];

  // Write-back value and error for one instruction, straight from the ISA rules
  function automatic void wbRef(input stim_t s, input int nsrc,
                                output logic [31:0] d, output logic e);
    int unsigned b;
    logic [31:0] lane;
    b = s.alu % 4;
    d = '0;
    e = 1'b0;
    if (int'(s.sel) >= nsrc) begin
      d = '0;
      e = 1'b1;
    end else if (s.sel == 2'd0) begin
      d = s.alu;
    end else if (s.sel == 2'd2) begin
      d = s.pc4;
    end else if (s.sel == 2'd3) begin
      d = s.imm;
    end else begin
      case (s.sz)
        2'd0: begin d = s.mem; e = (b != 0); end
        2'd1: begin
          lane = (s.mem >> (16 * (b / 2))) & 32'h0000_FFFF;
          d = (s.sg && lane >= 32'h8000) ? lane + 32'hFFFF_0000 : lane;
          e = (b % 2 == 1);
        end
        2'd2: begin
          lane = (s.mem >> (8 * b)) & 32'h0000_00FF;
          d = (s.sg && lane >= 32'h80) ? lane + 32'hFFFF_FF00 : lane;
        end
        default: begin d = s.mem; e = 1'b1; end
      endcase
    end
  endfunction

  function automatic stim_t base();
    stim_t s;
    s.rstn = 1'b1; s.stall = 1'b0; s.flush = 1'b0; s.valid = 1'b0; s.rwi = 1'b0;
    s.sel = '0; s.wreg = '0; s.sz = '0; s.sg = 1'b0;
    s.alu = $urandom; s.mem = $urandom; s.pc4 = $urandom; s.imm = $urandom;
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input stim_t s);
    logic [31:0] d;
    logic        e;
    exp_t        x;
    @(negedge clk);
    rst_n = s.rstn; stall = s.stall; flush = s.flush; in_valid = s.valid;
    RegWrite_in = s.rwi; WbSel = s.sel; WriteReg_in = s.wreg;
    ResultadoF_ALU = s.alu; Exit_DataMem = s.mem; PC_plus4 = s.pc4; Imm_upper = s.imm;
    LoadSize = s.sz; LoadSigned = s.sg;
    for (int i = 0; i < 2; i++) begin
      wbRef(s, nsrcOf[i], d, e);
      if (!s.rstn) mCnt[i] = 0;
      else if (mRw[i] && !s.stall && mCnt[i] < cntMax[i]) mCnt[i] = mCnt[i] + 1;
      if (!s.rstn || s.flush) begin
        mData[i] = '0; mReg[i] = '0; mRw[i] = 1'b0; mValid[i] = 1'b0; mErr[i] = 1'b0;
        mCare[i] = 1'b1;
      end else if (!s.stall) begin
        mData[i]  = d;
        mReg[i]   = s.wreg;
        mValid[i] = s.valid;
        mErr[i]   = s.valid && e;
        mRw[i]    = s.valid && s.rwi && (s.wreg != 0) && !e;
        mCare[i]  = !(s.sel == 2'd1 && s.sz == 2'd3);
      end
      x.data = mData[i]; x.wreg = mReg[i]; x.rw = mRw[i]; x.valid = mValid[i];
      x.err = mErr[i]; x.cnt = mCnt[i]; x.dataCare = mCare[i];
      exp_q.push_back(x);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic compareSet(input string tag, input exp_t e, input logic [31:0] d,
                            input logic [4:0] r, input logic rw, input logic v,
                            input logic er, input logic [31:0] cnt);
    if (e.dataCare) check({tag, ".Write_Data"}, d, e.data);
    check({tag, ".WriteReg"}, 32'(r), 32'(e.wreg));
    check({tag, ".RegWrite"}, 32'(rw), 32'(e.rw));
    check({tag, ".wb_valid"}, 32'(v), 32'(e.valid));
    check({tag, ".wb_err"}, 32'(er), 32'(e.err));
    check({tag, ".wb_count"}, cnt, 32'(e.cnt));
  endtask

  exp_t ea, eb;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() >= 2) begin
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      compareSet("A", ea, aData, aReg, aRw, aValid, aErr, 32'(aCount));
      compareSet("B", eb, bData, bReg, bRw, bValid, bErr, 32'(bCount));
    end
  end

  // ---------------- stimulus ----------------
  stim_t s;
  initial begin
    for (int i = 0; i < 2; i++) begin
      mData[i] = '0; mReg[i] = '0; mRw[i] = 1'b0; mValid[i] = 1'b0; mErr[i] = 1'b0;
      mCnt[i] = 0; mCare[i] = 1'b1;
    end

    // reset
    s = base(); s.rstn = 1'b0; apply(s); apply(s);

    // ALU write to r8, then idle so the retired write is counted
    s = base(); s.valid = 1; s.rwi = 1; s.sel = 2'd0; s.alu = 32'h0000_1234; s.wreg = 5'd8; apply(s);
    s = base(); apply(s);

    // sub-word loads from 0x80FF_7F01
    s = base(); s.valid = 1; s.rwi = 1; s.sel = 2'd1; s.mem = 32'h80FF_7F01; s.wreg = 5'd9;
    s.alu = 32'h1000_0003; s.sz = 2'b10; s.sg = 1; apply(s);
    s.sg = 0; apply(s);
    s.alu = 32'h1000_0002; s.sz = 2'b01; s.sg = 1; apply(s);
    s.alu = 32'h1000_0000; s.sz = 2'b00; apply(s);

    // misaligned half, misaligned word, reserved size, then LUI (illegal in dutB)
    s = base(); s.valid = 1; s.rwi = 1; s.sel = 2'd1; s.wreg = 5'd10; s.alu = 32'h1000_0001;
    s.sz = 2'b01; apply(s);
    s.alu = 32'h1000_0002; s.sz = 2'b00; apply(s);
    s.alu = 32'h1000_0000; s.sz = 2'b11; apply(s);
    s = base(); s.valid = 1; s.rwi = 1; s.sel = 2'd3; s.wreg = 5'd11; s.imm = 32'hABCD_0000; apply(s);
    s = base(); apply(s);

    // valid write, three stalls with changing inputs, then stall+flush
    s = base(); s.valid = 1; s.rwi = 1; s.sel = 2'd0; s.wreg = 5'd12; apply(s);
    for (int i = 0; i < 3; i++) begin
      s = base(); s.stall = 1; s.valid = 1; s.rwi = 1; s.sel = 2'd2; s.wreg = 5'(13 + i); apply(s);
    end
    s = base(); apply(s);
    s = base(); s.valid = 1; s.rwi = 1; s.wreg = 5'd14; apply(s);
    s = base(); s.stall = 1; s.flush = 1; s.valid = 1; s.rwi = 1; s.wreg = 5'd15; apply(s);

    // link write to $zero is suppressed
    s = base(); s.valid = 1; s.rwi = 1; s.sel = 2'd2; s.wreg = 5'd0; s.pc4 = 32'h0040_0008; apply(s);
    s = base(); apply(s);

    // back-to-back writes past both counters' saturation points
    for (int i = 0; i < 18; i++) begin
      s = base(); s.valid = 1; s.rwi = 1; s.sel = 2'(i % 3); s.sz = 2'b10; s.wreg = 5'(1 + i); apply(s);
    end
    s = base(); apply(s);

    // reset while a write is held by stall
    s = base(); s.valid = 1; s.rwi = 1; s.wreg = 5'd20; apply(s);
    s = base(); s.stall = 1; apply(s);
    s = base(); s.stall = 1; s.rstn = 0; apply(s);
    s = base(); apply(s);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = base();
      s.rstn  = ($urandom_range(0, 49) != 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.rwi   = ($urandom_range(0, 3) != 0);
      s.sel   = 2'($urandom_range(0, 3));
      s.wreg  = 5'($urandom_range(0, 31));
      s.sz    = 2'($urandom_range(0, 3));
      s.sg    = 1'($urandom_range(0, 1));
      apply(s);
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
